// File: rtl/io_mmio_if.sv
// Core-side data-access bus into the I/O region: request fields plus the
// registered load data returned one cycle later.
interface io_mmio_if;
  logic        io_en;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  wea;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_en, addr, re, wea, wdata, input rdata);
  modport slave  (input io_en, addr, re, wea, wdata, output rdata);
endinterface

// File: rtl/io_mmio_responder.sv
// I/O-space responder: UART tx holding register, UART rx FIFO, sticky status,
// cycle and retired-instruction counters. Load data is registered (1-cycle).
module io_mmio_responder #(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  io_mmio_if.slave    bus,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam int PW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = RX_FIFO_DEPTH[PW:0];

  localparam logic [7:0] A_STATUS = 8'h00;
  localparam logic [7:0] A_RXDATA = 8'h04;
  localparam logic [7:0] A_TXDATA = 8'h08;
  localparam logic [7:0] A_CYCLE  = 8'h10;
  localparam logic [7:0] A_INSTRET = 8'h14;
  localparam logic [7:0] A_CNTRST = 8'h18;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       st_b0;
    logic [7:0] off;
  } req_t;

  req_t req;
  assign req.ld    = bus.io_en & bus.re;
  assign req.st    = bus.io_en & (|bus.wea);
  assign req.st_b0 = bus.io_en & bus.wea[0];
  assign req.off   = bus.addr[7:0];

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:8], bus.wdata[31:8]};

  // ---------------- rx FIFO ----------------
  logic [7:0]    rx_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [PW:0]   rx_cnt;
  logic          rx_empty, rx_full, rx_push, rx_pop;

  assign rx_empty      = (rx_cnt == '0);
  assign rx_full       = (rx_cnt == DEPTH_C);
  assign uart_rx_ready = ~rx_full;
  assign rx_push       = uart_rx_valid & ~rx_full;
  // An empty-FIFO pop is a no-op even if a byte lands in the same cycle.
  assign rx_pop        = req.ld & (req.off == A_RXDATA) & ~rx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
  end

  // ---------------- tx holding register ----------------
  logic tx_ovr, tx_fire, tx_st;
  assign tx_fire = uart_tx_valid & uart_tx_ready;
  assign tx_st   = req.st_b0 & (req.off == A_TXDATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      tx_ovr        <= 1'b0;
    end else begin
      // A drain in the same cycle frees the slot for the incoming byte.
      if (tx_st && (!uart_tx_valid || tx_fire)) begin
        uart_tx_valid <= 1'b1;
        uart_tx_data  <= bus.wdata[7:0];
      end else if (tx_fire) begin
        uart_tx_valid <= 1'b0;
      end
      if (tx_st && uart_tx_valid && !tx_fire) tx_ovr <= 1'b1;
      else if (req.st && req.off == A_STATUS) tx_ovr <= 1'b0;
    end
  end

  // ---------------- counters ----------------
  logic [31:0] cyc_cnt, ret_cnt;
  logic        cnt_clr;
  assign cnt_clr = req.st & (req.off == A_CNTRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end

  // ---------------- load path ----------------
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (req.off)
      A_STATUS:  rd_mux = {28'd0, rx_full, tx_ovr, ~rx_empty, ~uart_tx_valid};
      A_RXDATA:  rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr]};
      A_CYCLE:   rd_mux = cyc_cnt;
      A_INSTRET: rd_mux = ret_cnt;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus.rdata <= '0;
    else if (req.ld) bus.rdata <= rd_mux;
  end
endmodule
